// File: rtl/mips32_mem_pkg.sv
// Shared types for the MIPS32 unified-memory arbiter: requester/owner encodings and FSM states.
// Request vectors throughout use bit 0 = IF, bit 1 = DM, bit 2 = LD.
package mips32_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2,
    OWN_LD   = 2'd3
  } owner_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic logic [2:0] ownerMask(input owner_t owner);
    logic [2:0] mask;
    mask = 3'b000;
    case (owner)
      OWN_IF:  mask = 3'b001;
      OWN_DM:  mask = 3'b010;
      OWN_LD:  mask = 3'b100;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// Bundle of the three requester handshakes, the memory-side bus and the status outputs.
// The arbiter connects through the slave modport; the pipeline/loader/memory side uses master.
interface mips32_mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;

  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_ack;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic [1:0]    gnt_owner;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           ld_req, ld_addr, ld_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata, ld_ack,
           mem_en, mem_we, mem_addr, mem_wdata, busy, gnt_owner
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           ld_req, ld_addr, ld_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata, ld_ack,
           mem_en, mem_we, mem_addr, mem_wdata, busy, gnt_owner
  );
endinterface

// File: rtl/mips32_mem_prio_pick.sv
// Combinational winner select: LD > DM > IF, except a starved IF beats everyone.
// Requesters in the exclude mask (the one being acked) cannot win this round.
module mips32_mem_prio_pick
  import mips32_mem_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [2:0] i_exclude,
  input  logic       i_starve,
  output owner_t     o_winner
);

  logic [2:0] w_eligible;

  assign w_eligible = i_req & ~i_exclude;

  always_comb begin
    o_winner = OWN_NONE;
    if (i_starve && w_eligible[0]) begin
      o_winner = OWN_IF;
    end else if (w_eligible[2]) begin
      o_winner = OWN_LD;
    end else if (w_eligible[1]) begin
      o_winner = OWN_DM;
    end else if (w_eligible[0]) begin
      o_winner = OWN_IF;
    end
  end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Arbiter sharing one single-port unified memory between fetch, data and loader requesters.
// One access at a time: IDLE/RESP arbitrate, ISSUE strobes the memory, WAIT covers read latency.
module mips32_mem_arbiter
  import mips32_mem_pkg::*;
#(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk1,
  input  logic                 reset,
  mips32_mem_arbiter_if.slave  bus
);

  localparam int CW = $clog2(RD_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  state_t          r_state;
  owner_t          r_owner;
  owner_t          r_gntOwner;
  logic            r_accWe;
  logic [CW-1:0]   r_waitCnt;
  logic [SW-1:0]   r_starveCnt;
  logic            r_memEn;
  logic            r_memWe;
  logic [AW-1:0]   r_memAddr;
  logic [DW-1:0]   r_memWdata;
  logic            r_ifAck;
  logic            r_dmAck;
  logic            r_ldAck;
  logic [DW-1:0]   r_ifRdata;
  logic [DW-1:0]   r_dmRdata;
  logic            r_busy;

  logic [2:0]      w_req;
  logic [2:0]      w_exclude;
  logic            w_starve;
  owner_t          w_winner;
  logic [AW-1:0]   w_addr;
  logic            w_we;
  logic [DW-1:0]   w_wdata;

  assign w_req     = {bus.ld_req, bus.dm_req, bus.if_req};
  assign w_exclude = (r_state == RESP) ? ownerMask(r_owner) : 3'b000;
  assign w_starve  = (r_starveCnt >= SW'(STARVE_MAX));

  mips32_mem_prio_pick u_pick (
    .i_req     (w_req),
    .i_exclude (w_exclude),
    .i_starve  (w_starve),
    .o_winner  (w_winner)
  );

  always_comb begin
    w_addr  = bus.if_addr;
    w_we    = 1'b0;
    w_wdata = '0;
    case (w_winner)
      OWN_DM: begin
        w_addr  = bus.dm_addr;
        w_we    = bus.dm_we;
        w_wdata = bus.dm_wdata;
      end
      OWN_LD: begin
        w_addr  = bus.ld_addr;
        w_we    = 1'b1;
        w_wdata = bus.ld_wdata;
      end
      default: ;
    endcase
  end

  // Strobes and acks are single-cycle pulses; everything else holds until the next grant.
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_state     <= IDLE;
      r_owner     <= OWN_NONE;
      r_gntOwner  <= OWN_NONE;
      r_accWe     <= 1'b0;
      r_waitCnt   <= '0;
      r_starveCnt <= '0;
      r_memEn     <= 1'b0;
      r_memWe     <= 1'b0;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
      r_ifAck     <= 1'b0;
      r_dmAck     <= 1'b0;
      r_ldAck     <= 1'b0;
      r_ifRdata   <= '0;
      r_dmRdata   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_memEn <= 1'b0;
      r_memWe <= 1'b0;
      r_ifAck <= 1'b0;
      r_dmAck <= 1'b0;
      r_ldAck <= 1'b0;
      if (!bus.if_req) r_starveCnt <= '0;

      case (r_state)
        IDLE, RESP: begin
          if (w_winner != OWN_NONE) begin
            r_state    <= ISSUE;
            r_owner    <= w_winner;
            r_gntOwner <= w_winner;
            r_busy     <= 1'b1;
            r_accWe    <= w_we;
            r_memEn    <= 1'b1;
            r_memWe    <= w_we;
            r_memAddr  <= w_addr;
            r_memWdata <= w_wdata;
            if (w_winner == OWN_IF) begin
              r_starveCnt <= '0;
            end else if (bus.if_req && !w_starve) begin
              r_starveCnt <= r_starveCnt + SW'(1);
            end
          end else begin
            r_state    <= IDLE;
            r_owner    <= OWN_NONE;
            r_gntOwner <= OWN_NONE;
            r_busy     <= 1'b0;
          end
        end
        ISSUE: begin
          r_state   <= WAIT;
          r_waitCnt <= '0;
        end
        WAIT: begin
          if (r_waitCnt == CW'(RD_LAT - 1)) begin
            r_state <= RESP;
            case (r_owner)
              OWN_IF: begin
                r_ifAck   <= 1'b1;
                r_ifRdata <= bus.mem_rdata;
              end
              OWN_DM: begin
                r_dmAck <= 1'b1;
                if (!r_accWe) r_dmRdata <= bus.mem_rdata;
              end
              OWN_LD:  r_ldAck <= 1'b1;
              default: ;
            endcase
          end else begin
            r_waitCnt <= r_waitCnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = r_memEn;
  assign bus.mem_we    = r_memWe;
  assign bus.mem_addr  = r_memAddr;
  assign bus.mem_wdata = r_memWdata;
  assign bus.if_ack    = r_ifAck;
  assign bus.if_rdata  = r_ifRdata;
  assign bus.dm_ack    = r_dmAck;
  assign bus.dm_rdata  = r_dmRdata;
  assign bus.ld_ack    = r_ldAck;
  assign bus.busy      = r_busy;
  assign bus.gnt_owner = r_gntOwner;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Self-checking bench: instance A (RD_LAT=1, STARVE_MAX=4) and instance B (RD_LAT=3, STARVE_MAX=2),
// each behind a behavioural memory; acks are scored against an expected-ack queue.
module tb_mips32_mem_arbiter;

  typedef struct {
    logic [1:0]  owner;
    logic [31:0] data;
    int          cyc;
    bit          chk;
  } exp_t;

  logic clk1;
  logic reset;
  int   checks;
  int   errors;
  exp_t expQ[$];

  logic [31:0] memA [1024];
  logic [31:0] memB [1024];
  logic [31:0] pipeB1, pipeB2;

  mips32_mem_arbiter_if #(.AW(10), .DW(32)) busA ();
  mips32_mem_arbiter_if #(.AW(10), .DW(32)) busB ();

  mips32_mem_arbiter #(.AW(10), .DW(32), .RD_LAT(1), .STARVE_MAX(4)) dutA (
    .clk1(clk1), .reset(reset), .bus(busA)
  );

  mips32_mem_arbiter #(.AW(10), .DW(32), .RD_LAT(3), .STARVE_MAX(2)) dutB (
    .clk1(clk1), .reset(reset), .bus(busB)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // Read data is only meaningful RD_LAT cycles after the strobe; other cycles carry a poison word.
  always @(posedge clk1) begin
    if (busA.mem_en && busA.mem_we) memA[busA.mem_addr] <= busA.mem_wdata;
    busA.mem_rdata <= (busA.mem_en && !busA.mem_we) ? memA[busA.mem_addr] : 32'hdeadbeef;
  end

  always @(posedge clk1) begin
    if (busB.mem_en && busB.mem_we) memB[busB.mem_addr] <= busB.mem_wdata;
    pipeB1         <= (busB.mem_en && !busB.mem_we) ? memB[busB.mem_addr] : 32'hdeadbeef;
    pipeB2         <= pipeB1;
    busB.mem_rdata <= pipeB2;
  end

  task automatic test_reset();
    busA.if_req = 0; busA.if_addr = '0; busA.dm_req = 0; busA.dm_we = 0;
    busA.dm_addr = '0; busA.dm_wdata = '0; busA.ld_req = 0; busA.ld_addr = '0; busA.ld_wdata = '0;
    busB.if_req = 0; busB.if_addr = '0; busB.dm_req = 0; busB.dm_we = 0;
    busB.dm_addr = '0; busB.dm_wdata = '0; busB.ld_req = 0; busB.ld_addr = '0; busB.ld_wdata = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk1);
    checks++;
    if ({busA.busy, busA.mem_en, busA.mem_we, busA.if_ack, busA.dm_ack, busA.ld_ack, busA.gnt_owner} !== 8'h00 ||
        busA.if_rdata !== 32'h0 || busA.dm_rdata !== 32'h0 || busA.mem_addr !== 10'h0) begin
      errors++;
      $display("[TB] FAIL reset_A: busy=%b en=%b gnt=%0d if_rdata=%h, required all zero",
               busA.busy, busA.mem_en, busA.gnt_owner, busA.if_rdata);
    end
    checks++;
    if ({busB.busy, busB.mem_en, busB.mem_we, busB.if_ack, busB.dm_ack, busB.ld_ack, busB.gnt_owner} !== 8'h00 ||
        busB.if_rdata !== 32'h0 || busB.dm_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_B: busy=%b en=%b gnt=%0d, required all zero",
               busB.busy, busB.mem_en, busB.gnt_owner);
    end
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    @(negedge clk1);
    busA.if_req = 1; busA.if_addr = 10'd5;
    @(negedge clk1);
    checks++;
    if (busA.mem_en !== 1'b1 || busA.mem_we !== 1'b0 || busA.mem_addr !== 10'd5) begin
      errors++;
      $display("[TB] FAIL fetch_issue: en=%b we=%b addr=%0d, required en=1 we=0 addr=5",
               busA.mem_en, busA.mem_we, busA.mem_addr);
    end
    checks++;
    if (busA.busy !== 1'b1 || busA.gnt_owner !== 2'd1) begin
      errors++;
      $display("[TB] FAIL fetch_owner: busy=%b gnt=%0d, required busy=1 gnt=1", busA.busy, busA.gnt_owner);
    end
    @(negedge clk1);
    checks++;
    if (busA.if_ack !== 1'b0 || busA.mem_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fetch_wait: ack=%b en=%b, required 0 0", busA.if_ack, busA.mem_en);
    end
    @(negedge clk1);
    checks++;
    if (busA.if_ack !== 1'b1 || busA.if_rdata !== 32'h2842002d) begin
      errors++;
      $display("[TB] FAIL fetch_ack: ack=%b rdata=%h, required 1 2842002d", busA.if_ack, busA.if_rdata);
    end
    busA.if_req = 0;
    @(negedge clk1);
    checks++;
    if (busA.if_ack !== 1'b0 || busA.busy !== 1'b0 || busA.gnt_owner !== 2'd0) begin
      errors++;
      $display("[TB] FAIL fetch_idle: ack=%b busy=%b gnt=%0d, required 0 0 0",
               busA.if_ack, busA.busy, busA.gnt_owner);
    end
  endtask

  task automatic test_priority();
    exp_t        e;
    logic [1:0]  own;
    logic [31:0] rd;
    bit          multi;
    multi = 0;
    @(negedge clk1);
    busA.ld_req = 1; busA.ld_addr = 10'd50; busA.ld_wdata = 32'h0000abcd;
    busA.dm_req = 1; busA.dm_we = 0; busA.dm_addr = 10'd99;
    busA.if_req = 1; busA.if_addr = 10'd5;
    expQ.push_back('{owner: 2'd3, data: 32'h0, cyc: 3, chk: 0});
    expQ.push_back('{owner: 2'd2, data: 32'd85, cyc: 6, chk: 1});
    expQ.push_back('{owner: 2'd1, data: 32'h2842002d, cyc: 9, chk: 1});
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk1);
      if (c == 1) busA.dm_addr = 10'd120;
      if (c == 4) busA.dm_addr = 10'd99;
      if ((32'(busA.ld_ack) + 32'(busA.dm_ack) + 32'(busA.if_ack)) > 1) multi = 1;
      own = busA.ld_ack ? 2'd3 : busA.dm_ack ? 2'd2 : busA.if_ack ? 2'd1 : 2'd0;
      if (own != 2'd0) begin
        checks++;
        rd = (own == 2'd1) ? busA.if_rdata : busA.dm_rdata;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL prio_extra_ack: owner %0d at cycle %0d, required no ack", own, c);
        end else begin
          e = expQ.pop_front();
          if (own !== e.owner || c != e.cyc || (e.chk && rd !== e.data)) begin
            errors++;
            $display("[TB] FAIL prio_ack: owner %0d cycle %0d data %h, required owner %0d cycle %0d data %h",
                     own, c, rd, e.owner, e.cyc, e.data);
          end
        end
        if (busA.ld_ack) busA.ld_req = 0;
        if (busA.dm_ack) busA.dm_req = 0;
        if (busA.if_ack) busA.if_req = 0;
      end
    end
    checks++;
    if (expQ.size() != 0 || multi) begin
      errors++;
      $display("[TB] FAIL prio_complete: %0d acks missing, overlap=%0b, required 0 and 0", expQ.size(), multi);
    end
    expQ.delete();
    checks++;
    if (memA[50] !== 32'h0000abcd) begin
      errors++;
      $display("[TB] FAIL loader_write: mem[50]=%h, required 0000abcd", memA[50]);
    end
  endtask

  task automatic test_store_load();
    @(negedge clk1);
    busA.dm_req = 1; busA.dm_we = 1; busA.dm_addr = 10'd121; busA.dm_wdata = 32'd130;
    @(negedge clk1);
    checks++;
    if (busA.mem_en !== 1'b1 || busA.mem_we !== 1'b1 || busA.mem_addr !== 10'd121 || busA.mem_wdata !== 32'd130) begin
      errors++;
      $display("[TB] FAIL store_issue: en=%b we=%b addr=%0d wdata=%0d, required 1 1 121 130",
               busA.mem_en, busA.mem_we, busA.mem_addr, busA.mem_wdata);
    end
    repeat (2) @(negedge clk1);
    checks++;
    if (busA.dm_ack !== 1'b1 || busA.dm_rdata !== 32'd85 || busA.if_rdata !== 32'h2842002d) begin
      errors++;
      $display("[TB] FAIL store_ack: ack=%b dm_rdata=%0d if_rdata=%h, required 1 85 2842002d",
               busA.dm_ack, busA.dm_rdata, busA.if_rdata);
    end
    busA.dm_req = 0; busA.dm_we = 0;
    @(negedge clk1);
    busA.dm_req = 1; busA.dm_addr = 10'd121;
    repeat (3) @(negedge clk1);
    checks++;
    if (busA.dm_ack !== 1'b1 || busA.dm_rdata !== 32'd130 || busA.if_rdata !== 32'h2842002d) begin
      errors++;
      $display("[TB] FAIL load_back: ack=%b dm_rdata=%0d if_rdata=%h, required 1 130 2842002d",
               busA.dm_ack, busA.dm_rdata, busA.if_rdata);
    end
    busA.dm_req = 0;
  endtask

  task automatic test_reset_mid_access();
    bit sawAck;
    sawAck = 0;
    @(negedge clk1);
    busA.if_req = 1; busA.if_addr = 10'd7;
    repeat (2) @(negedge clk1);
    reset = 1'b1;
    @(negedge clk1);
    checks++;
    if (busA.busy !== 1'b0 || busA.mem_en !== 1'b0 || busA.if_ack !== 1'b0 ||
        busA.gnt_owner !== 2'd0 || busA.if_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid: busy=%b en=%b ack=%b gnt=%0d if_rdata=%h, required all zero",
               busA.busy, busA.mem_en, busA.if_ack, busA.gnt_owner, busA.if_rdata);
    end
    reset = 1'b0;
    busA.if_req = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk1);
      if (busA.if_ack) sawAck = 1;
    end
    checks++;
    if (sawAck) begin
      errors++;
      $display("[TB] FAIL reset_no_ack: if_ack pulsed=%b, required 0", sawAck);
    end
    busA.if_req = 1;
    repeat (3) @(negedge clk1);
    checks++;
    if (busA.if_ack !== 1'b1 || busA.if_rdata !== 32'h11110007) begin
      errors++;
      $display("[TB] FAIL reset_rereq: ack=%b rdata=%h, required 1 11110007", busA.if_ack, busA.if_rdata);
    end
    busA.if_req = 0;
  endtask

  task automatic test_long_latency();
    bit early;
    early = 0;
    @(negedge clk1);
    busB.if_req = 1; busB.if_addr = 10'd7;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk1);
      if (c == 1) begin
        checks++;
        if (busB.mem_en !== 1'b1 || busB.mem_addr !== 10'd7) begin
          errors++;
          $display("[TB] FAIL lat3_issue: en=%b addr=%0d, required 1 7", busB.mem_en, busB.mem_addr);
        end
      end
      if (c >= 2 && c <= 4 && busB.if_ack) early = 1;
    end
    checks++;
    if (early || busB.if_ack !== 1'b1 || busB.if_rdata !== 32'hfc000000) begin
      errors++;
      $display("[TB] FAIL lat3_ack: early=%b ack=%b rdata=%h, required 0 1 fc000000",
               early, busB.if_ack, busB.if_rdata);
    end
    busB.if_req = 0;
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [1:0]  own;
    logic [31:0] rd;
    @(negedge clk1);
    busB.ld_req = 1; busB.ld_addr = 10'd200; busB.ld_wdata = 32'h00000055;
    busB.dm_req = 1; busB.dm_we = 0; busB.dm_addr = 10'd7;
    busB.if_req = 1; busB.if_addr = 10'd7;
    expQ.push_back('{owner: 2'd3, data: 32'h0, cyc: 5, chk: 0});
    expQ.push_back('{owner: 2'd2, data: 32'hfc000000, cyc: 10, chk: 1});
    expQ.push_back('{owner: 2'd1, data: 32'hfc000000, cyc: 15, chk: 1});
    expQ.push_back('{owner: 2'd3, data: 32'h0, cyc: 20, chk: 0});
    expQ.push_back('{owner: 2'd2, data: 32'hfc000000, cyc: 25, chk: 1});
    expQ.push_back('{owner: 2'd1, data: 32'hfc000000, cyc: 30, chk: 1});
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk1);
      own = busB.ld_ack ? 2'd3 : busB.dm_ack ? 2'd2 : busB.if_ack ? 2'd1 : 2'd0;
      if (own != 2'd0) begin
        checks++;
        rd = (own == 2'd1) ? busB.if_rdata : busB.dm_rdata;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL starve_extra_ack: owner %0d at cycle %0d, required no ack", own, c);
        end else begin
          e = expQ.pop_front();
          if (own !== e.owner || c != e.cyc || (e.chk && rd !== e.data)) begin
            errors++;
            $display("[TB] FAIL starve_ack: owner %0d cycle %0d data %h, required owner %0d cycle %0d data %h",
                     own, c, rd, e.owner, e.cyc, e.data);
          end
        end
      end
      if (c == 30) begin
        busB.ld_req = 0; busB.dm_req = 0; busB.if_req = 0;
      end
    end
    checks++;
    if (expQ.size() != 0 || busB.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL starve_complete: %0d acks missing busy=%b, required 0 0", expQ.size(), busB.busy);
    end
    expQ.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    memA[5]   = 32'h2842002d;
    memA[7]   = 32'h11110007;
    memA[99]  = 32'h00000999;
    memA[120] = 32'd85;
    memB[7]   = 32'hfc000000;
    test_reset();
    test_fetch();
    test_priority();
    test_store_load();
    test_reset_mid_access();
    test_long_latency();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
